// File: rtl/mem_request_ctrl.sv
// Single-outstanding load/store initiator for the data memory port; screens bad requests.
// Accept-to-response: store 2, load READ_LATENCY+1, error 1 cycles; no new request accepted until the response is consumed.
module mem_request_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 20,
  parameter int MEM_SIZE      = 16384,
  parameter int READ_LATENCY  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic                     req_byte,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_error,
  output logic                     busy,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  output logic                     mem_we,
  output logic                     mem_re,
  output logic                     mem_be,
  input  logic [DATA_WIDTH-1:0]    mem_read_data
);

  localparam int CW = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
  localparam int PADW = DATA_WIDTH - 8;
  localparam logic [ADDRESS_WIDTH:0] MEM_LIMIT = (ADDRESS_WIDTH + 1)'(MEM_SIZE);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  typedef struct packed {
    logic                     we;
    logic                     re;
    logic                     be;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]    write_data;
  } mem_cmd_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  mem_cmd_t                cmd_q, cmd_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_error_q, rsp_error_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    req_err;

  // Byte accesses may be unaligned; word accesses must sit on a 4-byte boundary.
  assign req_err = ({1'b0, req_addr} >= MEM_LIMIT) || (!req_byte && (req_addr[1:0] != 2'b00));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    cmd_d.we    = 1'b0;
    cmd_d.re    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_error_d = rsp_error_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            cmd_d.address = req_addr;
            cmd_d.be      = req_byte;
            if (req_write) begin
              state_d          = WRITE;
              cmd_d.we         = 1'b1;
              cmd_d.write_data = req_byte ? {{PADW{1'b0}}, req_wdata[7:0]} : req_wdata;
            end else begin
              state_d  = READ;
              cmd_d.re = 1'b1;
              cnt_d    = CW'(READ_LATENCY);
            end
          end
        end
      end

      WRITE: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_error_d = 1'b0;
        rsp_rdata_d = '0;
      end

      READ: begin
        // Read data is sampled on the edge that ends the last strobe cycle.
        if (cnt_q <= CW'(1)) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b0;
          rsp_rdata_d = cmd_q.be ? {{PADW{1'b0}}, mem_read_data[7:0]} : mem_read_data;
        end else begin
          cnt_d    = cnt_q - CW'(1);
          cmd_d.re = 1'b1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_error      = rsp_error_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign mem_we         = cmd_q.we;
  assign mem_re         = cmd_q.re;
  assign mem_be         = cmd_q.be;
  assign mem_address    = cmd_q.address;
  assign mem_write_data = cmd_q.write_data;

endmodule
